// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   state_t            - arbiter FSM state encoding
//   WAIT_LOW_TIMEOUT   - WAIT_LOW cycles with i_txrdy still high before the
//                        handshake is declared broken
//   CFG_*              - bit positions inside one channel's 3-bit framing field
//                        {eight, pen, ohel}
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_LOW  = 3'd2,
        ST_WAIT_HIGH = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    localparam int WAIT_LOW_TIMEOUT = 4;
    localparam int WL_CNT_W         = $clog2(WAIT_LOW_TIMEOUT);

    localparam int CFG_W     = 3;
    localparam int CFG_EIGHT = 2;
    localparam int CFG_PEN   = 1;
    localparam int CFG_OHEL  = 0;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundles the requester-side, transmitter-side and status signals of the
// UART transmit arbiter.
//   i_req   [3:0]  level request per channel
//   i_data  [31:0] channel k byte on [8k+7:8k]
//   i_cfg   [11:0] channel k framing on [3k+2:3k] = {eight, pen, ohel}
//   i_rate  [18:0] shared baud divisor
//   i_txrdy        UART_TX ready
//   o_write        one-cycle write strobe to UART_TX
//   o_byte  [7:0]  byte being transmitted
//   o_eight/o_pen/o_ohel  framing of the current frame
//   o_rate  [18:0] baud divisor of the current frame
//   o_ack   [3:0]  one-hot grant pulse
//   o_owner [1:0]  channel of the current or last frame
//   o_busy         arbiter not idle
//   o_err          sticky handshake error
// Modports: slave = the arbiter, master = requesters plus UART_TX side.
interface uart_tx_arbiter_if;

    logic [3:0]  i_req;
    logic [31:0] i_data;
    logic [11:0] i_cfg;
    logic [18:0] i_rate;
    logic        i_txrdy;
    logic        o_write;
    logic [7:0]  o_byte;
    logic        o_eight;
    logic        o_pen;
    logic        o_ohel;
    logic [18:0] o_rate;
    logic [3:0]  o_ack;
    logic [1:0]  o_owner;
    logic        o_busy;
    logic        o_err;

    modport slave (
        input  i_req, i_data, i_cfg, i_rate, i_txrdy,
        output o_write, o_byte, o_eight, o_pen, o_ohel, o_rate,
        output o_ack, o_owner, o_busy, o_err
    );

    modport master (
        output i_req, i_data, i_cfg, i_rate, i_txrdy,
        input  o_write, o_byte, o_eight, o_pen, o_ohel, o_rate,
        input  o_ack, o_owner, o_busy, o_err
    );

endinterface

// File: rtl/rr_pick4.sv
// rr_pick4
// Combinational round-robin selector over four requests.
//   req   [3:0]  request vector
//   last  [1:0]  most recently granted channel
//   valid        at least one request is set
//   idx   [1:0]  winner: first set bit searching from last+1 upward (mod 4)
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest set bit after
    // 'last' is the final assignment; offset 4 wraps to 'last' itself,
    // giving the previous winner the lowest priority.
    always_comb begin
        valid = 1'b0;
        idx   = last;
        for (int off = 4; off >= 1; off--) begin
            if (req[last + 2'(off)]) begin
                valid = 1'b1;
                idx   = last + 2'(off);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter between four requesters. A round-robin grant
// latches the winner's byte, framing and the shared baud divisor, strobes
// o_write once, follows the i_txrdy low/high handshake of the transmitter and
// then enforces IDLE_GAP idle cycles before the next grant.
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      uart_tx_arbiter_if.slave (request, transmitter and status signals)
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NUM_REQ    = 4,
    parameter int          IDLE_GAP   = 16,
    parameter logic [18:0] RESET_RATE = 19'd109
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    uart_tx_arbiter_if.slave bus
);

    localparam logic [7:0]         GAP_LOAD = (IDLE_GAP > 0) ? 8'(IDLE_GAP - 1) : 8'd0;
    localparam logic [NUM_REQ-1:0] ACK_ONE  = NUM_REQ'(1);

    state_t              state;
    logic [1:0]          last_grant;
    logic [WL_CNT_W-1:0] wl_cnt;
    logic [7:0]          gap_cnt;

    logic                pick_valid;
    logic [1:0]          pick_idx;
    logic [CFG_W-1:0]    pick_cfg;

    rr_pick4 u_pick (
        .req   (bus.i_req),
        .last  (last_grant),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign pick_cfg = bus.i_cfg[CFG_W*pick_idx +: CFG_W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= 2'd3;
            wl_cnt      <= '0;
            gap_cnt     <= 8'd0;
            bus.o_write <= 1'b0;
            bus.o_ack   <= '0;
            bus.o_busy  <= 1'b0;
            bus.o_err   <= 1'b0;
            bus.o_owner <= 2'd0;
            bus.o_byte  <= 8'h00;
            bus.o_eight <= 1'b0;
            bus.o_pen   <= 1'b0;
            bus.o_ohel  <= 1'b0;
            bus.o_rate  <= RESET_RATE;
        end else begin
            // Strobes default low; only the transitions below raise them.
            bus.o_write <= 1'b0;
            bus.o_ack   <= '0;
            case (state)
                ST_IDLE: begin
                    if (bus.i_txrdy && pick_valid) begin
                        bus.o_byte  <= bus.i_data[8*pick_idx +: 8];
                        bus.o_eight <= pick_cfg[CFG_EIGHT];
                        bus.o_pen   <= pick_cfg[CFG_PEN];
                        bus.o_ohel  <= pick_cfg[CFG_OHEL];
                        bus.o_rate  <= bus.i_rate;
                        bus.o_ack   <= ACK_ONE << pick_idx;
                        bus.o_owner <= pick_idx;
                        last_grant  <= pick_idx;
                        bus.o_busy  <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    bus.o_write <= 1'b1;
                    wl_cnt      <= '0;
                    state       <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    // The transmitter must drop i_txrdy to acknowledge the
                    // write; staying high too long means the strobe was lost.
                    if (!bus.i_txrdy) begin
                        state <= ST_WAIT_HIGH;
                    end else if (wl_cnt == WL_CNT_W'(WAIT_LOW_TIMEOUT - 1)) begin
                        bus.o_err  <= 1'b1;
                        bus.o_busy <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        wl_cnt <= wl_cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (bus.i_txrdy) begin
                        if (IDLE_GAP == 0) begin
                            bus.o_busy <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            gap_cnt <= GAP_LOAD;
                            state   <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        bus.o_busy <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    bus.o_busy <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
// Directed scenarios for uart_tx_arbiter. The main process drives requests
// and plays the UART_TX handshake; every grant it expects is pushed into a
// scoreboard queue which an independent monitor drains whenever o_ack fires.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [7:0]  b;
        logic [2:0]  cfg;
        logic [18:0] rate;
    } exp_t;

    exp_t exp_q[$];
    logic expect_write = 1'b0;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(
        .NUM_REQ    (4),
        .IDLE_GAP   (16),
        .RESET_RATE (19'd109)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [1:0] ch, input logic [7:0] b,
                            input logic [2:0] cfg, input logic [18:0] rate);
        exp_t e;
        e.ch = ch; e.b = b; e.cfg = cfg; e.rate = rate;
        exp_q.push_back(e);
    endtask

    task automatic timeout_fail(input string name, input int budget);
        total++;
        bad++;
        $display("FAIL %s: event not seen within %0d cycles, required it", name, budget);
    endtask

    task automatic wait_ack(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.o_ack != 4'd0) seen = 1'b1;
        end
        if (!seen) timeout_fail("ack_timeout", budget);
    endtask

    task automatic wait_write(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.o_write) seen = 1'b1;
        end
        if (!seen) timeout_fail("write_timeout", budget);
    endtask

    task automatic wait_idle(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (!bus.o_busy) seen = 1'b1;
        end
        if (!seen) timeout_fail("idle_timeout", budget);
    endtask

    task automatic drop_req();
        @(posedge clk);
        #1 bus.i_req = 4'b0000;
    endtask

    // UART_TX model: after the write strobe, drop ready for 'low' cycles.
    task automatic serve(input int low);
        wait_write(10);
        @(posedge clk);
        #1 bus.i_txrdy = 1'b0;
        repeat (low) @(posedge clk);
        #1 bus.i_txrdy = 1'b1;
    endtask

    task automatic check_reset_outputs();
        check("rst_write", 32'(bus.o_write), 32'd0);
        check("rst_ack",   32'(bus.o_ack),   32'd0);
        check("rst_busy",  32'(bus.o_busy),  32'd0);
        check("rst_err",   32'(bus.o_err),   32'd0);
        check("rst_owner", 32'(bus.o_owner), 32'd0);
        check("rst_byte",  32'(bus.o_byte),  32'd0);
        check("rst_cfg",   32'({bus.o_eight, bus.o_pen, bus.o_ohel}), 32'd0);
        check("rst_rate",  32'(bus.o_rate),  32'd109);
    endtask

    // Scoreboard monitor
    initial begin : monitor
        exp_t       e;
        logic [3:0] one;
        one = 4'b0001;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                expect_write = 1'b0;
            end else begin
                if (expect_write) begin
                    check("write_after_ack", 32'(bus.o_write), 32'd1);
                    expect_write = 1'b0;
                end else if (bus.o_write) begin
                    check("write_unexpected", 32'(bus.o_write), 32'd0);
                end
                if (bus.o_ack != 4'd0) begin
                    if (exp_q.size() == 0) begin
                        check("ack_unexpected", 32'(bus.o_ack), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("ack_onehot", 32'(bus.o_ack),   32'(one << e.ch));
                        check("owner",      32'(bus.o_owner), 32'(e.ch));
                        check("byte",       32'(bus.o_byte),  32'(e.b));
                        check("framing",    32'({bus.o_eight, bus.o_pen, bus.o_ohel}), 32'(e.cfg));
                        check("rate",       32'(bus.o_rate),  32'(e.rate));
                        expect_write = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int t0;
        rst_n       = 1'b0;
        bus.i_req   = 4'b0000;
        bus.i_data  = 32'd0;
        bus.i_cfg   = 12'd0;
        bus.i_rate  = 19'd0;
        bus.i_txrdy = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // No grant while the transmitter is not ready
        bus.i_txrdy = 1'b0;
        bus.i_req   = 4'b0001;
        bus.i_data  = 32'h0000_003A;
        bus.i_rate  = 19'd100;
        repeat (5) begin
            @(negedge clk);
            check("noready_ack",  32'(bus.o_ack),  32'd0);
            check("noready_busy", 32'(bus.o_busy), 32'd0);
        end

        // Single request on channel 0
        push_exp(2'd0, 8'h3A, 3'b000, 19'd100);
        @(posedge clk);
        #1 bus.i_txrdy = 1'b1;
        wait_ack(10);
        drop_req();
        serve(3);
        wait_idle(100);

        // Contention from a fresh reset: order 0,1,2,3,0
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.i_data = 32'hD3C2_B1A0;
        bus.i_cfg  = 12'b101_100_011_010;
        bus.i_rate = 19'd200;
        push_exp(2'd0, 8'hA0, 3'b010, 19'd200);
        push_exp(2'd1, 8'hB1, 3'b011, 19'd200);
        push_exp(2'd2, 8'hC2, 3'b100, 19'd200);
        push_exp(2'd3, 8'hD3, 3'b101, 19'd200);
        push_exp(2'd0, 8'hA0, 3'b010, 19'd200);
        bus.i_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_ack(60);
            serve(3);
        end
        wait_ack(60);
        drop_req();
        serve(3);
        wait_idle(100);

        // Framing and rate on channel 2, held while the inputs change
        bus.i_data = 32'h005C_0000;
        bus.i_cfg  = 12'b000_110_000_000;
        bus.i_rate = 19'd54;
        push_exp(2'd2, 8'h5C, 3'b110, 19'd54);
        bus.i_req = 4'b0100;
        wait_ack(60);
        @(posedge clk);
        #1;
        bus.i_req  = 4'b0000;
        bus.i_data = 32'd0;
        bus.i_cfg  = 12'd0;
        bus.i_rate = 19'd999;
        wait_write(10);
        @(posedge clk);
        #1 bus.i_txrdy = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_eight", 32'(bus.o_eight), 32'd1);
        check("hold_pen",   32'(bus.o_pen),   32'd1);
        check("hold_ohel",  32'(bus.o_ohel),  32'd0);
        check("hold_rate",  32'(bus.o_rate),  32'd54);
        check("hold_byte",  32'(bus.o_byte),  32'h5C);
        check("hold_busy",  32'(bus.o_busy),  32'd1);
        @(posedge clk);
        #1 bus.i_txrdy = 1'b1;
        wait_idle(100);

        // Gap: channel 1 held, ready rise to next ack is 18 cycles
        bus.i_data = 32'h0000_7700;
        bus.i_cfg  = 12'd0;
        bus.i_rate = 19'd300;
        push_exp(2'd1, 8'h77, 3'b000, 19'd300);
        push_exp(2'd1, 8'h77, 3'b000, 19'd300);
        bus.i_req = 4'b0010;
        wait_ack(60);
        wait_write(10);
        @(posedge clk);
        #1 bus.i_txrdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.i_txrdy = 1'b1;
        t0 = cyc;
        wait_ack(60);
        check("gap_ready_to_ack", 32'(cyc - t0), 32'd18);
        drop_req();
        serve(3);
        wait_idle(100);

        // Handshake error: ready never drops after the write
        bus.i_data = 32'h0000_00E1;
        bus.i_rate = 19'd77;
        push_exp(2'd0, 8'hE1, 3'b000, 19'd77);
        bus.i_req = 4'b0001;
        wait_ack(60);
        drop_req();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("err_during_wait_low",  32'(bus.o_err),  32'd0);
            check("busy_during_wait_low", 32'(bus.o_busy), 32'd1);
        end
        @(negedge clk);
        check("err_set",        32'(bus.o_err),  32'd1);
        check("err_back_idle",  32'(bus.o_busy), 32'd0);
        repeat (5) @(negedge clk);
        check("err_sticky",     32'(bus.o_err),  32'd1);
        check("err_stays_idle", 32'(bus.o_busy), 32'd0);

        // Reset during WAIT_HIGH, then re-arbitration from channel 0
        bus.i_data = 32'h0099_0000;
        bus.i_rate = 19'd88;
        push_exp(2'd2, 8'h99, 3'b000, 19'd88);
        bus.i_req = 4'b0100;
        wait_ack(60);
        drop_req();
        wait_write(10);
        @(posedge clk);
        #1 bus.i_txrdy = 1'b0;
        @(posedge clk);
        #1;
        check("err_sticky_before_reset", 32'(bus.o_err),  32'd1);
        check("busy_in_wait_high",       32'(bus.o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        bus.i_txrdy = 1'b1;
        bus.i_req   = 4'b1001;
        bus.i_data  = 32'h4400_0033;
        bus.i_cfg   = 12'b111_000_000_001;
        bus.i_rate  = 19'd66;
        push_exp(2'd0, 8'h33, 3'b001, 19'd66);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ack(60);
        drop_req();
        serve(3);
        wait_idle(100);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (fixed at 4 in this revision).
REQ-002 The block SHALL have parameter IDLE_GAP, default 16, meaning the minimum idle i_clk cycles between frames (0 allowed).
REQ-003 The block SHALL have parameter RESET_RATE, default 19'd109, meaning the baud divisor driven out of reset.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: i_clk in 1 (rising edge) and i_rst_n in 1 (asynchronous, active-low).
REQ-005 The block SHALL have these requester-side ports:
- i_req in 4: level request, bit k for channel k.
- i_data in 32: channel k byte on [8k+7:8k].
- i_cfg in 12: channel k framing on [3k+2:3k] = {eight, pen, ohel}.
- i_rate in 19: shared baud divisor.
REQ-006 The block SHALL have these transmitter-side ports:
- o_write out 1.
- o_byte out 8.
- o_eight out 1.
- o_pen out 1.
- o_ohel out 1.
- o_rate out 19.
- i_txrdy in 1: UART_TX ready.
REQ-007 The block SHALL have these status ports:
- o_ack out 4: one-hot grant pulse.
- o_owner out 2: channel of the current or last frame.
- o_busy out 1: state is not IDLE.
- o_err out 1: sticky handshake error.

Function
REQ-008 The block SHALL implement the states IDLE, ISSUE, WAIT_LOW, WAIT_HIGH and GAP.
REQ-009 In IDLE with i_txrdy=1 and any i_req bit set, the block SHALL grant one channel.
- Search order is round-robin starting at (last_grant+1) mod 4.
- The grant latches that channel's byte, cfg and i_rate into o_byte, o_eight/o_pen/o_ohel and o_rate.
- The grant pulses the matching o_ack bit for exactly that cycle.
- The grant updates last_grant and o_owner, then the block enters ISSUE.
REQ-010 In IDLE with i_txrdy=0, the block SHALL make no grant, even if requests are pending.
REQ-011 ISSUE SHALL assert o_write for exactly one cycle, then the block SHALL enter WAIT_LOW.
REQ-012 o_byte, the framing outputs and o_rate SHALL be stable from the grant cycle until the next grant.
REQ-013 WAIT_LOW SHALL move to WAIT_HIGH when i_txrdy=0.
REQ-014 If i_txrdy stays 1 for 4 consecutive WAIT_LOW cycles, the block SHALL set o_err (sticky) and return to IDLE.
REQ-015 WAIT_HIGH SHALL wait indefinitely for i_txrdy=1.
- Then it enters GAP with the gap counter loaded to IDLE_GAP-1.
- If IDLE_GAP=0, it goes directly to IDLE.
REQ-016 GAP SHALL decrement the 8-bit gap counter each cycle and enter IDLE in the cycle after it reads 0.
REQ-017 A requester SHALL hold i_req until its o_ack; a request that drops before grant SHALL simply not be considered.
REQ-018 A channel whose i_req is still high after its ack SHALL be treated as a new request and SHALL be served after all other pending channels.
REQ-019 Requests arriving in any state other than IDLE SHALL wait; they SHALL NOT be lost, provided the requester holds i_req.
REQ-020 With a single requester, frames SHALL be back-to-back, separated only by the IDLE_GAP cycles plus 1 IDLE cycle.

Reset
REQ-021 While i_rst_n=0, the block SHALL force these values:
- state = IDLE.
- last_grant = 3, so channel 0 has first priority.
- o_write, o_ack, o_busy and o_err = 0.
- o_owner = 0, o_byte = 8'h00.
- o_eight, o_pen and o_ohel = 0.
- o_rate = RESET_RATE.
- gap counter = 0.
REQ-022 Reset mid-frame SHALL abandon the frame with no ack or write afterwards; the requester SHALL re-request.

Structure
REQ-023 The state encoding, the WAIT_LOW timeout constant (4) and the cfg bit positions SHALL live in a shared package, uart_pkg.
REQ-024 The round-robin selector SHALL be one sub-module, rr_pick4: inputs req[3:0] and last[1:0], outputs valid and idx[1:0], purely combinational.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Single request: i_req=4'b0001, i_data[7:0]=8'h3A, i_txrdy=1 -> o_ack=0001 for 1 cycle, o_write pulse the next cycle, o_byte=8'h3A.
- Contention: i_req=4'b1111 held, with a UART_TX model -> grant order 0,1,2,3,0.
- Framing and rate: channel 2 with cfg 3'b110 and i_rate=19'd54 -> o_eight=1, o_pen=1, o_ohel=0 and o_rate=54 held through WAIT_HIGH.
- Error: i_txrdy forced to 1 after write -> o_err=1 exactly 4 WAIT_LOW cycles later, state returns to IDLE, o_err holds until reset.
- Gap: IDLE_GAP=16 with channel 1 held -> i_txrdy rise to next o_ack = 18 cycles.
- Reset: i_rst_n low during WAIT_HIGH -> all outputs reach their reset values immediately, and re-arbitration starts at channel 0.
